// File: rtl/seq_mem_d1_ctrl.sv
// Request-side controller for a one-port sequential memory (seq_mem_d1_*).
// Optional out-of-bounds rejection is enabled by defining SEQ_MEM_CTRL_BOUNDS_CHECK_EN.
module seq_mem_d1_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 4,
    parameter int unsigned IDX_SIZE = 4,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [IDX_SIZE-1:0] req_addr,
    input  logic [WIDTH-1:0]    req_data,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic                rsp_err,
    output logic [WIDTH-1:0]    rsp_data,

    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic [WIDTH-1:0]    mem_in,
    input  logic [WIDTH-1:0]    mem_out,
    input  logic                mem_read_done,
    input  logic                mem_write_done
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IDX_SIZE-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]      in_q, in_d;
    logic                  ren_q, ren_d;
    logic                  wen_q, wen_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  addr_oob;
    logic                  done_seen;

`ifdef SEQ_MEM_CTRL_BOUNDS_CHECK_EN
    localparam logic [IDX_SIZE:0] SizeLim = (IDX_SIZE + 1)'(SIZE);
    assign addr_oob = {1'b0, req_addr} >= SizeLim;
`else
    assign addr_oob = 1'b0;
`endif

    // Only the strobe matching the latched command kind counts.
    assign done_seen = wr_q ? mem_write_done : mem_read_done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        in_d    = in_q;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        wr_d    = wr_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wr_d   = req_write;
                    addr_d = req_addr;
                    in_d   = req_data;
                    err_d  = 1'b0;
                    data_d = '0;
                    if (addr_oob) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        // Enables are registered here so they are high exactly during ISSUE.
                        ren_d   = !req_write;
                        wen_d   = req_write;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (done_seen) begin
                    // Memory clobbers out on writes, so never capture it then.
                    data_d  = wr_q ? '0 : mem_out;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            in_q    <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            in_q    <= in_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign rsp_valid    = (state_q == StResp);
    assign rsp_write    = wr_q;
    assign rsp_err      = err_q;
    assign rsp_data     = data_q;
    assign mem_addr0    = addr_q;
    assign mem_in       = in_q;
    assign mem_read_en  = ren_q;
    assign mem_write_en = wen_q;

endmodule

// File: tb/tb_seq_mem_d1_ctrl.sv
// Scoreboard bench for seq_mem_d1_ctrl with a behavioural one-port sequential memory.
module tb_seq_mem_d1_ctrl;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned SIZE     = 4;
    localparam int unsigned IDX_SIZE = 4;
    localparam int unsigned TIMEOUT  = 15;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic                req_ready;
    logic                req_write;
    logic [IDX_SIZE-1:0] req_addr;
    logic [WIDTH-1:0]    req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_write;
    logic                rsp_err;
    logic [WIDTH-1:0]    rsp_data;
    logic [IDX_SIZE-1:0] mem_addr0;
    logic                mem_read_en;
    logic                mem_write_en;
    logic [WIDTH-1:0]    mem_in;
    logic [WIDTH-1:0]    mem_out;
    logic                mem_read_done;
    logic                mem_write_done;

    seq_mem_d1_ctrl #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .IDX_SIZE (IDX_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_write      (rsp_write),
        .rsp_err        (rsp_err),
        .rsp_data       (rsp_data),
        .mem_addr0      (mem_addr0),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .mem_in         (mem_in),
        .mem_out        (mem_out),
        .mem_read_done  (mem_read_done),
        .mem_write_done (mem_write_done)
    );

    always #5 clk = ~clk;

    // Memory: done one cycle after the enable; out is clobbered on writes.
    logic [WIDTH-1:0] mem_arr [16] = '{default: '0};
    logic             mute = 1'b0;
    initial begin
        mem_out        = '0;
        mem_read_done  = 1'b0;
        mem_write_done = 1'b0;
    end
    always @(posedge clk) begin
        mem_read_done  <= 1'b0;
        mem_write_done <= 1'b0;
        if (mem_read_en) begin
            mem_out       <= mem_arr[mem_addr0];
            mem_read_done <= !mute;
        end
        if (mem_write_en) begin
            mem_arr[mem_addr0] <= mem_in;
            mem_out            <= 32'hBAD0_BAD0;
            mem_write_done     <= !mute;
        end
    end

    typedef struct packed {
        logic             write;
        logic             err;
        logic [WIDTH-1:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   both_en = 0;
    int   rd_cycles = 0;
    int   wr_cycles = 0;
    int   exp_rd = 0;
    int   exp_wr = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_read_en && mem_write_en) both_en++;
        if (mem_read_en) rd_cycles++;
        if (mem_write_en) wr_cycles++;
    end

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_write", {31'd0, rsp_write}, {31'd0, e.write});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_data", rsp_data, e.data);
            end
        end
    end

    // Waits for req_ready, presents the command for one edge; returns 1ns after acceptance.
    task automatic issue(input logic w, input logic [IDX_SIZE-1:0] a, input logic [WIDTH-1:0] d,
                         input logic exp_err, input logic [WIDTH-1:0] exp_data,
                         input bit expect_rsp, input bit hits_mem);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        if (expect_rsp) sb.push_back('{write: w, err: exp_err, data: exp_data});
        if (hits_mem) begin
            if (w) exp_wr++;
            else exp_rd++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_flags"}, {30'd0, rsp_write, rsp_err}, 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_mem_en"}, {30'd0, mem_read_en, mem_write_en}, 32'd0);
        check({tag, "_mem_addr0"}, {28'd0, mem_addr0}, 32'd0);
        check({tag, "_mem_in"}, mem_in, 32'd0);
    endtask

    initial begin
        time t_acc [8];
        int  n;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Write then read with latency check.
        issue(1'b1, 4'd2, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b1, 1'b1);
        drain();
        issue(1'b0, 4'd2, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        @(negedge clk);
        check("issue_read_en", {31'd0, mem_read_en}, 32'd1);
        check("issue_addr0", {28'd0, mem_addr0}, 32'd2);
        check("lat_edge1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("lat_edge2", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("lat_edge3", {31'd0, rsp_valid}, 32'd1);
        drain();

        // Back-to-back writes then reads.
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 4'(i), 32'h10 + 32'(i), 1'b0, 32'd0, 1'b1, 1'b1);
            t_acc[i] = $time;
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 4'(i), 32'd0, 1'b0, 32'h10 + 32'(i), 1'b1, 1'b1);
            t_acc[4 + i] = $time;
        end
        check("b2b_period", 32'(t_acc[5] - t_acc[4]), 32'd40);
        drain();

        // Backpressure on a read response.
        issue(1'b1, 4'd1, 32'hA5A5_A5A5, 1'b0, 32'd0, 1'b1, 1'b1);
        drain();
        rsp_ready = 1'b0;
        issue(1'b0, 4'd1, 32'd0, 1'b0, 32'hA5A5_A5A5, 1'b1, 1'b1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_data", rsp_data, 32'hA5A5_A5A5);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_accepted", {30'd0, rsp_valid, req_ready}, 32'd1);
        drain();

        // Timeout: memory never signals done.
        mute = 1'b1;
        issue(1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
        n = 0;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("timeout_window", {31'd0, (n >= TIMEOUT && n <= TIMEOUT + 2)}, 32'd1);
        drain();
        mute = 1'b0;
        @(negedge clk);
        check("timeout_idle", {31'd0, req_ready}, 32'd1);

        // Reset while waiting: no response, outputs return to reset values at once.
        issue(1'b0, 4'd3, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check_reset_vals("rst_wait");
        @(posedge clk);
        #1 reset = 1'b0;
        issue(1'b0, 4'd3, 32'd0, 1'b0, 32'h13, 1'b1, 1'b1);
        drain();

        // Address beyond SIZE.
`ifdef SEQ_MEM_CTRL_BOUNDS_CHECK_EN
        issue(1'b0, 4'd7, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("oob_valid", {31'd0, rsp_valid}, 32'd1);
        check("oob_no_en", {31'd0, mem_read_en}, 32'd0);
`else
        issue(1'b0, 4'd7, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
        @(negedge clk);
        check("oob_read_en", {31'd0, mem_read_en}, 32'd1);
        check("oob_addr0", {28'd0, mem_addr0}, 32'd7);
`endif
        drain();

        repeat (3) @(negedge clk);
        check("never_both_en", both_en, 32'd0);
        check("read_en_cycles", rd_cycles, exp_rd);
        check("write_en_cycles", wr_cycles, exp_wr);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
